sprite_fifo_sched: RTL and testbench

Controller that shares one sprite_fifo instance between NUM_REQ sprite producers and a single draw-engine consumer.
- Write side: round-robin arbitration among producers.
- Read side: sequences FIFO pops into a one-entry output register with valid/ready.
- Frame start: drains stale entries.
- Issues at most one FIFO operation (re or we) per cycle, because the FIFO gives re priority and silently drops a simultaneous we.

---
 rtl/sprite_sched_pkg.sv | 23 ++
 rtl/sprite_fifo_sched_arbiter.sv | 42 ++++
 rtl/sprite_fifo_sched.sv | 164 ++++++++++++++++
 tb/tb_sprite_fifo_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite FIFO scheduler and its round-robin arbiter.
// Optional statistics counter is enabled by defining SPRITE_SCHED_STATS_EN.
package sprite_sched_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // Index width for a producer number; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_fifo_sched_arbiter.sv
// Combinational round-robin search: the first requester strictly after
// rr_ptr, wrapping at NUM_REQ. The caller owns and updates rr_ptr.
module sprite_rr_arbiter
    import sprite_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk the ring once starting after rr_ptr and keep the first hit.
    // NOTE: every variable in an always_comb gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                grant_idx = w_cand;
            end
        end
    end

    // One-hot grant only when the parent actually issues the write.
    always_comb begin
        grant = '0;
        if (grant_en && w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sprite_fifo_sched.sv
// Shares one sprite FIFO between NUM_REQ producers and one draw engine.
// Issues at most one FIFO op per cycle (the FIFO drops we when re is high),
// alternates reads and writes under contention, and drains the FIFO on
// frame_start. Define SPRITE_SCHED_STATS_EN to add the stall_cnt output.
module sprite_fifo_sched
    import sprite_sched_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int NUM_REQ   = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         enable,
    input  logic                         frame_start,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fifo_we,
    output logic                         fifo_re,
    output logic [BUS_WIDTH-1:0]         fifo_wdata,
    input  logic                         fifo_e,
    input  logic                         fifo_f,
    input  logic [BUS_WIDTH-1:0]         fifo_rdata,
    output logic                         out_valid,
    output logic [BUS_WIDTH-1:0]         out_data,
    input  logic                         out_ready,
    output logic                         flushing
`ifdef SPRITE_SCHED_STATS_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t               r_state;
    state_t               w_next_state;
    op_t                  r_last_op;
    op_t                  w_op;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic                 r_rd_inflight;
    logic                 r_out_valid;
    logic [BUS_WIDTH-1:0] r_out_data;
    logic                 w_any_req;
    logic                 w_rd_elig;
    logic                 w_wr_elig;

    assign w_any_req = |req_valid;

    sprite_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant_en  (fifo_we),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Eligibility: FLUSH pops regardless of enable and never writes; all ops
    // are held off while Reset is asserted so outputs sit at their reset values.
    always_comb begin
        w_rd_elig = 1'b0;
        w_wr_elig = 1'b0;
        if (!Reset) begin
            if (r_state == FLUSH) begin
                w_rd_elig = !fifo_e && !r_rd_inflight;
            end else begin
                w_rd_elig = enable && !fifo_e && !r_rd_inflight && (!r_out_valid || out_ready);
                w_wr_elig = enable && !fifo_f && w_any_req;
            end
        end
    end

    // Pick a single op; under contention alternate against the previous one.
    always_comb begin
        w_op = OP_NONE;
        if (w_rd_elig && w_wr_elig) begin
            w_op = (r_last_op == OP_WRITE) ? OP_READ : OP_WRITE;
        end else if (w_rd_elig) begin
            w_op = OP_READ;
        end else if (w_wr_elig) begin
            w_op = OP_WRITE;
        end
    end

    assign fifo_re    = (w_op == OP_READ);
    assign fifo_we    = (w_op == OP_WRITE);
    assign req_ready  = w_grant;
    assign fifo_wdata = fifo_we ? req_data[int'(w_grant_idx)*BUS_WIDTH +: BUS_WIDTH] : '0;
    assign flushing   = (r_state == FLUSH);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

    // Next state: any frame_start enters or extends FLUSH; leave once drained.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:     if (frame_start) w_next_state = FLUSH;
            FLUSH:   if (fifo_e && !r_rd_inflight && !frame_start) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arbitration pointer, last issued op and the one-deep read pipeline.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
            r_last_op     <= OP_WRITE;
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= fifo_re;
            if (fifo_we) begin
                r_rr_ptr <= w_grant_idx;
            end
            if (w_op != OP_NONE) begin
                r_last_op <= w_op;
            end
        end
    end

    // Output register: loads on a landing read, clears on handshake, and is
    // forced empty while flushing or on the frame_start edge.
    // NOTE: out_data is a datapath register but is still reset, so the draw engine never sees X.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (frame_start || (r_state == FLUSH)) begin
            r_out_valid <= 1'b0;
        end else if (r_rd_inflight) begin
            r_out_valid <= 1'b1;
            r_out_data  <= fifo_rdata;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef SPRITE_SCHED_STATS_EN
    // Saturating count of RUN cycles where a producer waits on a full FIFO.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (frame_start) begin
            stall_cnt <= '0;
        end else if ((r_state == RUN) && w_any_req && fifo_f && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_fifo_sched.sv
// Self-checking bench for sprite_fifo_sched: a queue-based FIFO stub, a
// behavioural scheduler model checked every cycle, a directed vector table,
// hand-written corner sequences and a randomized run.
module tb_sprite_fifo_sched;

    localparam int BW    = 16;
    localparam int NR    = 4;
    localparam int DEPTH = 8;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               enable = 1'b0;
    logic               frame_start = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*BW-1:0]   req_data = '0;
    logic [NR-1:0]      req_ready;
    logic               fifo_we;
    logic               fifo_re;
    logic [BW-1:0]      fifo_wdata;
    logic               fifo_e = 1'b1;
    logic               fifo_f = 1'b0;
    logic [BW-1:0]      fifo_rdata = '0;
    logic               out_valid;
    logic [BW-1:0]      out_data;
    logic               out_ready = 1'b0;
    logic               flushing;
`ifdef SPRITE_SCHED_STATS_EN
    logic [15:0]        stall_cnt;
`endif

    always #5 Clk = ~Clk;

    sprite_fifo_sched #(.BUS_WIDTH(BW), .NUM_REQ(NR)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .enable      (enable),
        .frame_start (frame_start),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_we     (fifo_we),
        .fifo_re     (fifo_re),
        .fifo_wdata  (fifo_wdata),
        .fifo_e      (fifo_e),
        .fifo_f      (fifo_f),
        .fifo_rdata  (fifo_rdata),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flushing    (flushing)
`ifdef SPRITE_SCHED_STATS_EN
        , .stall_cnt (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO stub ----------------
    logic [BW-1:0] envq[$];
    bit            force_full = 1'b0;

    task automatic env_refresh();
        fifo_e = (envq.size() == 0);
        fifo_f = force_full || (envq.size() >= DEPTH);
    endtask

    // ---------------- scheduler reference model ----------------
    bit            m_flush, m_pend, m_last_wr, m_ov;
    int            m_ptr, m_stall;
    logic [BW-1:0] m_od, m_land;

    task automatic model_reset();
        m_flush = 0; m_pend = 0; m_last_wr = 1; m_ov = 0;
        m_ptr = NR - 1; m_stall = 0; m_od = '0; m_land = '0;
    endtask

    // One clock: compare the current cycle, then advance stub and model.
    task automatic tick();
        bit            rd_ok, wr_ok, do_rd, do_wr;
        bit            pre_fe, pre_ff, pre_fs, pre_ordy, dut_re, dut_we;
        int            win;
        logic [NR-1:0] exp_rr, pre_rv;
        logic [BW-1:0] exp_wd, dut_wd;
        #1;
        rd_ok = m_flush ? (!fifo_e && !m_pend)
                        : (enable && !fifo_e && !m_pend && (!m_ov || out_ready));
        wr_ok = !m_flush && enable && !fifo_f && (req_valid != 0);
        do_rd = (rd_ok && wr_ok) ? m_last_wr : rd_ok;
        do_wr = wr_ok && !do_rd;
        win = -1;
        for (int k = 1; k <= NR; k++)
            if (win < 0 && req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
        exp_rr = '0;
        exp_wd = '0;
        if (do_wr) begin
            exp_rr[win] = 1'b1;
            exp_wd = req_data[win*BW +: BW];
        end
        check("req_ready", req_ready, exp_rr);
        check("fifo_we", fifo_we, do_wr);
        check("fifo_re", fifo_re, do_rd);
        check("fifo_wdata", fifo_wdata, exp_wd);
        check("we_re_exclusive", fifo_we & fifo_re, 0);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_od);
        check("flushing", flushing, m_flush);
`ifdef SPRITE_SCHED_STATS_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        pre_fe = fifo_e; pre_ff = fifo_f; pre_fs = frame_start; pre_ordy = out_ready;
        pre_rv = req_valid; dut_re = fifo_re; dut_we = fifo_we; dut_wd = fifo_wdata;
        @(posedge Clk);
        #1;
        if (dut_re) begin
            if (envq.size() > 0) fifo_rdata = envq.pop_front();
        end else if (dut_we && envq.size() < DEPTH) begin
            envq.push_back(dut_wd);
        end
        env_refresh();
        if (pre_fs || m_flush) m_ov = 0;
        else if (m_pend) begin m_ov = 1; m_od = m_land; end
        else if (m_ov && pre_ordy) m_ov = 0;
        if (do_rd) m_land = fifo_rdata;
        if (pre_fs) m_stall = 0;
        else if (!m_flush && pre_rv != 0 && pre_ff && m_stall < 65535) m_stall++;
        if (pre_fs) m_flush = 1;
        else if (m_flush && pre_fe && !m_pend) m_flush = 0;
        m_pend = do_rd;
        if (do_wr) m_ptr = win;
        if (do_rd) m_last_wr = 0;
        else if (do_wr) m_last_wr = 1;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1; enable = 1'b1; req_valid = '1; frame_start = 1'b0;
        out_ready = 1'b0; force_full = 1'b0; envq.delete(); fifo_rdata = '0;
        env_refresh(); model_reset();
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_fifo_we", fifo_we, 0);
        check("rst_fifo_re", fifo_re, 0);
        check("rst_fifo_wdata", fifo_wdata, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flushing", flushing, 0);
`ifdef SPRITE_SCHED_STATS_EN
        check("rst_stall_cnt", stall_cnt, 0);
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        req_valid = '0;
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        logic [BW-1:0] d2;
        logic          ordy;
        logic          e_we;
        logic          e_re;
        logic [NR-1:0] e_rr;
        logic          e_ov;
        logic [BW-1:0] e_od;
    } vec_t;

    vec_t vt[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'b0100, 16'h00A5, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 16'h0000};
        vt[1] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0000};
        vt[2] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000};
        vt[3] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h00A5};
        vt[4] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h00A5};
        vt[5] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h00A5};

        @(negedge Clk);

        // Single descriptor from producer 2 through an empty FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = vt[i].rv;
            req_data = '0;
            req_data[2*BW +: BW] = vt[i].d2;
            out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d_we", i), fifo_we, vt[i].e_we);
            check($sformatf("vec%0d_re", i), fifo_re, vt[i].e_re);
            check($sformatf("vec%0d_req_ready", i), req_ready, vt[i].e_rr);
            check($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            check($sformatf("vec%0d_out_data", i), out_data, vt[i].e_od);
            tick();
        end

        // Round robin with reads and writes alternating.
        begin
            int grants[$];
            int exp_g[5] = '{0, 1, 2, 3, 0};
            do_reset();
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) envq.push_back(BW'(16'h0100 + k));
            env_refresh();
            req_valid = '1;
            for (int c = 0; c < 10; c++) begin
                for (int p = 0; p < NR; p++) req_data[p*BW +: BW] = BW'($urandom);
                #1;
                if (req_ready != 0) grants.push_back($clog2(req_ready));
                check("rr_read_slot", fifo_re, (c % 2) == 0);
                check("rr_write_slot", fifo_we, (c % 2) == 1);
                tick();
            end
            check("rr_grant_count", grants.size(), 5);
            for (int k = 0; k < grants.size() && k < 5; k++)
                check($sformatf("rr_grant%0d", k), grants[k], exp_g[k]);
            req_valid = '0;
        end

        // FIFO full: no grants, reads drain, grant on the first non-full cycle.
        begin
            int reads = 0;
            do_reset();
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) envq.push_back(BW'(16'h0200 + k));
            force_full = 1'b1;
            env_refresh();
            req_valid = '1;
            for (int c = 0; c < 10; c++) begin
                #1;
                check("full_no_grant", req_ready, 0);
                if (fifo_re) reads++;
                tick();
            end
            check("full_reads", reads, 4);
`ifdef SPRITE_SCHED_STATS_EN
            check("stall_cnt_10", stall_cnt, 10);
`endif
            force_full = 1'b0;
            env_refresh();
            #1;
            check("grant_after_full", req_ready, 4'b0001);
            tick();
            req_valid = '0;
        end

        // Output held under back-pressure, pop issues the cycle ready rises.
        begin
            bit got;
            do_reset();
            out_ready = 1'b0;
            req_valid = 4'b0001;
            req_data[0 +: BW] = 16'h1234;
            #1;
            check("hold_w0", req_ready, 4'b0001);
            tick();
            req_valid = 4'b0010;
            req_data[BW +: BW] = 16'h5678;
            got = 0;
            for (int c = 0; c < 6 && !got; c++) begin
                #1;
                if (req_ready[1]) got = 1;
                tick();
            end
            check("hold_w1_granted", got, 1);
            req_valid = '0;
            got = 0;
            for (int c = 0; c < 6 && !got; c++) begin
                #1;
                if (out_valid) got = 1;
                tick();
            end
            check("hold_loaded", got, 1);
            for (int c = 0; c < 3; c++) begin
                #1;
                check("hold_data", out_data, 16'h1234);
                check("hold_valid", out_valid, 1);
                check("hold_no_re", fifo_re, 0);
                tick();
            end
            out_ready = 1'b1;
            #1;
            check("hold_release_re", fifo_re, 1);
            repeat (4) tick();
        end

        // Frame-start flush of five queued entries.
        begin
            int  re_cnt = 0;
            int  last_re = 0;
            bit  back = 0;
            do_reset();
            out_ready = 1'b0;
            enable = 1'b0;
            for (int k = 0; k < 5; k++) envq.push_back(BW'(16'h0300 + k));
            env_refresh();
            frame_start = 1'b1;
            #1;
            check("fs_cycle_no_re", fifo_re, 0);
            tick();
            frame_start = 1'b0;
            for (int c = 0; c < 30 && !back; c++) begin
                #1;
                if (c == 0) check("flush_entered", flushing, 1);
                if (!flushing) back = 1;
                else begin
                    check("flush_out_valid", out_valid, 0);
                    if (fifo_re) begin
                        if (re_cnt > 0) check("flush_re_gap", c - last_re, 2);
                        last_re = c;
                        re_cnt++;
                    end
                end
                tick();
            end
            check("flush_re_count", re_cnt, 5);
            check("flush_returned", back, 1);
        end

        // Short reset pulse while a read is in flight: nothing may land.
        do_reset();
        out_ready = 1'b1;
        envq.push_back(16'hBEEF);
        env_refresh();
        #1;
        check("pre_reset_re", fifo_re, 1);
        tick();
        Reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        envq.delete(); fifo_rdata = '0; env_refresh(); model_reset();
        #1;
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("no_land_after_reset", out_valid, 0);
            tick();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            frame_start = ($urandom_range(0, 59) == 0);
            req_valid = NR'($urandom);
            for (int p = 0; p < NR; p++) req_data[p*BW +: BW] = BW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            force_full = ($urandom_range(0, 15) == 0);
            env_refresh();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
